mul_iter_core: RTL and testbench
================================

# mul_iter_core

Iterative half-precision multiplier core that sits directly upstream of `mul_normalizer`. It accepts two FP16 operands over a valid/ready handshake and computes the product sign and the biased exponent sum. It also produces the raw 22-bit mantissa product with a sequential shift-add datapath, and flags zero results. Its `out_exponent`/`out_mantissa_prod` feed the normalizer's `exponent`/`mantissa_prod` directly.

## Interface
- `EXP_BIAS`, default 15: exponent bias subtracted from the sum of operand exponents.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: core can accept operands (IDLE only).
- `a` in 16: FP16 operand {sign, exp[4:0], frac[9:0]}.
- `b` in 16: FP16 operand, same format.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `out_sign` out 1: a[15]^b[15].
- `out_exponent` out 5: biased exponent for the normalizer.
- `out_mantissa_prod` out 22: {1,fa}×{1,fb}, unsigned.
- `out_zero` out 1: result flushed to zero.

## Operation
- States: IDLE, MUL, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch the operands and go to MUL.
  - Iteration counter cleared; accumulator cleared.
- Operand decode:
  - Mantissa = {1, frac}, 11 bits.
  - An operand with exp field 0 is treated as zero; denormals are flushed.
  - Exp field 31 is treated as a normal number; no Inf/NaN handling.
- Exponent: 7-bit signed intermediate `e = ea + eb - EXP_BIAS`.
  - If either operand is zero, or `e < 1`: `out_zero`=1, `out_exponent`=0, `out_mantissa_prod`=0.
  - If `e > 30`: saturate. `out_exponent`=30, `out_mantissa_prod`=22'h1FFFFF, which normalizes to max finite 0x7BFF.
  - Otherwise: `out_exponent`=e[4:0], `out_mantissa_prod` = the full product.
- MUL, per cycle:
  - If multiplier LSB is 1: accumulator += multiplicand.
  - Multiplicand shifts left 1; multiplier shifts right 1.
  - Fixed 11 iterations, then go to DONE.
  - Zero/saturate cases still run all iterations; their outputs are overridden at DONE.
- DONE:
  - `out_valid`=1; outputs held stable.
  - On `out_ready`, return to IDLE.
- `out_ready` while `out_valid`=0 is ignored. `in_valid` outside IDLE is ignored; operands are not sampled.
- `out_sign` is valid for zero and saturated results as well.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0. `out_sign`, `out_exponent`, `out_mantissa_prod` and `out_zero` are all 0.
- Latency: the accept edge is E0. `out_valid` rises after edge E11, i.e. 11 clocks later (6 with radix-4).
- Output handshake: on the edge where `out_valid && out_ready`, go to IDLE; `in_ready`=1 in the next cycle.
- Throughput: one result per 13 cycles at best (8 with radix-4).
- Back-to-back: no overlap; new operands are only accepted in IDLE.
- `out_valid` stays high and outputs stay constant until accepted (no drop under backpressure).
- `rst_n` low at any time, mid-MUL or in DONE: immediate return to reset values. The in-flight operation is discarded.

## Configuration
- Macro `MUL_RADIX4_EN`.
- Defined:
  - Radix-4 iteration: each cycle adds 0/1×/2×/3× the multiplicand, with 3× precomputed at accept.
  - Multiplier is zero-extended to 12 bits and shifted right 2 per cycle; multiplicand shifts left 2.
  - 6 iterations; latency 6.
- Undefined: radix-2, 11 iterations, latency 11.
- Results must be bit-identical in both builds.

## Test plan
- 1.0×1.0: a=0x3C00, b=0x3C00 -> `out_sign`=0, `out_exponent`=15, `out_mantissa_prod`=22'h100000, `out_zero`=0, `out_valid` exactly 11 cycles (6 radix-4) after accept.
- 1.5×1.5 and sign: a=0x3E00, b=0x3E00 -> exp 15, prod 22'h240000 (bit21 set). a=0xC000, b=0x4200 -> sign 1, exp 17, prod 22'h180000.
- Zero/underflow: a=0x0000, b=0x4500 -> `out_zero`=1, exp 0, prod 0. a=0x0400, b=0x0400 (e=-13) -> `out_zero`=1.
- Overflow: a=0x7800, b=0x7800 (e=45) -> exp 30, prod 22'h1FFFFF, `out_zero`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> outputs constant, `in_ready`=0, `in_valid` pulses ignored. Then `out_ready`=1 -> IDLE, next operands accepted one cycle later.
- Reset mid-MUL: assert `rst_n`=0 at iteration 5 -> all outputs 0 and `in_ready`=1 asynchronously. After release, a fresh 0x3C00×0x3C00 gives the correct result with no residue.

Source files
------------

// File: rtl/mul_iter_core.sv
// Iterative FP16 multiplier front end: sign, biased exponent and raw 22-bit mantissa product.
// Build option MUL_RADIX4_EN selects a radix-4 iteration (6 cycles) instead of radix-2 (11 cycles).
module mul_iter_core #(
    parameter int EXP_BIAS = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [4:0]  out_exponent,
    output logic [21:0] out_mantissa_prod,
    output logic        out_zero
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE; out_valid is high only in DONE and holds until accepted.
`ifdef MUL_RADIX4_EN
    localparam int ITERS = 6;
    localparam int MW    = 12;
`else
    localparam int ITERS = 11;
    localparam int MW    = 11;
`endif
    localparam logic signed [6:0] BIAS7 = 7'(EXP_BIAS);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [21:0]   acc_q, acc_d;
    logic [21:0]   mcand_q, mcand_d;
    logic [MW-1:0] mplier_q, mplier_d;
    logic [4:0]    ea_q, ea_d, eb_q, eb_d;
    logic          sgn_q, sgn_d;
    logic          out_sign_q, out_sign_d;
    logic [4:0]    out_exp_q, out_exp_d;
    logic [21:0]   out_mant_q, out_mant_d;
    logic          out_zero_q, out_zero_d;
    logic signed [6:0] e_sum;
`ifdef MUL_RADIX4_EN
    logic [21:0]   mc3_q, mc3_d;
`endif

    assign e_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS7;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        sgn_d      = sgn_q;
        out_sign_d = out_sign_q;
        out_exp_d  = out_exp_q;
        out_mant_d = out_mant_q;
        out_zero_d = out_zero_q;
`ifdef MUL_RADIX4_EN
        mc3_d      = mc3_q;
`endif
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);

        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                acc_d = 22'd0;
                if (in_valid) begin
                    state_d  = MUL;
                    mcand_d  = {11'd0, 1'b1, a[9:0]};
                    mplier_d = MW'({1'b1, b[9:0]});
                    ea_d     = a[14:10];
                    eb_d     = b[14:10];
                    sgn_d    = a[15] ^ b[15];
`ifdef MUL_RADIX4_EN
                    mc3_d    = {11'd0, 1'b1, a[9:0]} + {10'd0, 1'b1, a[9:0], 1'b0};
`endif
                end
            end
            MUL: begin
`ifdef MUL_RADIX4_EN
                case (mplier_q[1:0])
                    2'd1:    acc_d = acc_q + mcand_q;
                    2'd2:    acc_d = acc_q + (mcand_q << 1);
                    2'd3:    acc_d = acc_q + mc3_q;
                    default: acc_d = acc_q;
                endcase
                mcand_d  = mcand_q << 2;
                mc3_d    = mc3_q << 2;
                mplier_d = mplier_q >> 2;
`else
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
`endif
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(ITERS - 1)) begin
                    // Zero and saturation override whatever the datapath produced.
                    state_d    = DONE;
                    out_sign_d = sgn_q;
                    if (ea_q == 5'd0 || eb_q == 5'd0 || e_sum < 7'sd1) begin
                        out_zero_d = 1'b1;
                        out_exp_d  = 5'd0;
                        out_mant_d = 22'd0;
                    end else if (e_sum > 7'sd30) begin
                        out_zero_d = 1'b0;
                        out_exp_d  = 5'd30;
                        out_mant_d = 22'h1FFFFF;
                    end else begin
                        out_zero_d = 1'b0;
                        out_exp_d  = e_sum[4:0];
                        out_mant_d = acc_d;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            acc_q      <= 22'd0;
            mcand_q    <= 22'd0;
            mplier_q   <= '0;
            ea_q       <= 5'd0;
            eb_q       <= 5'd0;
            sgn_q      <= 1'b0;
            out_sign_q <= 1'b0;
            out_exp_q  <= 5'd0;
            out_mant_q <= 22'd0;
            out_zero_q <= 1'b0;
`ifdef MUL_RADIX4_EN
            mc3_q      <= 22'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            sgn_q      <= sgn_d;
            out_sign_q <= out_sign_d;
            out_exp_q  <= out_exp_d;
            out_mant_q <= out_mant_d;
            out_zero_q <= out_zero_d;
`ifdef MUL_RADIX4_EN
            mc3_q      <= mc3_d;
`endif
        end
    end

    assign out_sign          = out_sign_q;
    assign out_exponent      = out_exp_q;
    assign out_mantissa_prod = out_mant_q;
    assign out_zero          = out_zero_q;

endmodule

// File: tb/tb_mul_iter_core.sv
// Self-checking bench for mul_iter_core: directed test-plan vectors plus random operands
// compared against an arithmetic reference model through an expected-result queue.
module tb_mul_iter_core;

`ifdef MUL_RADIX4_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 11;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [4:0]  out_exponent;
    logic [21:0] out_mantissa_prod;
    logic        out_zero;

    int n_checks = 0;
    int n_fail   = 0;
    logic [28:0] exp_q[$];

    mul_iter_core #(.EXP_BIAS(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exponent(out_exponent),
        .out_mantissa_prod(out_mantissa_prod), .out_zero(out_zero)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference model: {sign, zero, exponent, mantissa product}
    function automatic logic [28:0] model(input logic [15:0] x, input logic [15:0] y);
        int ex = int'(x[14:10]);
        int ey = int'(y[14:10]);
        int e  = ex + ey - 15;
        logic s = x[15] ^ y[15];
        int unsigned p;
        if (ex == 0 || ey == 0 || e < 1) return {s, 1'b1, 5'd0, 22'd0};
        if (e > 30) return {s, 1'b0, 5'd30, 22'h1FFFFF};
        p = (1024 + int'(x[9:0])) * (1024 + int'(y[9:0]));
        return {s, 1'b0, 5'(e), 22'(p)};
    endfunction

    function automatic logic [28:0] dut_result();
        return {out_sign, out_zero, out_exponent, out_mantissa_prod};
    endfunction

    // Driver: one full transaction. hold = cycles of backpressure in DONE; poke = noise on in_valid/out_ready.
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input int hold, input bit poke);
        logic [28:0] want;
        int cycles;
        check("in_ready_idle", in_ready, 1);
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        exp_q.push_back(model(op_a, op_b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            if (poke) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                a = 16'($urandom);
                b = 16'($urandom);
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("latency", cycles, LAT);
        want = exp_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            check("result", dut_result(), want);
            check("in_ready_busy", in_ready, 0);
            check("out_valid_held", out_valid, 1);
            if (i < hold) begin
                if (poke) begin
                    in_valid = 1'($urandom_range(0, 1));
                    a = 16'($urandom);
                    b = 16'($urandom);
                end
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after", in_ready, 1);
        check("out_valid_after", out_valid, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0;
        repeat (3) @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", dut_result(), 29'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed test-plan vectors (expected values written out literally)
        run_op(16'h3C00, 16'h3C00, 0, 0);
        check("one_x_one", dut_result(), {1'b0, 1'b0, 5'd15, 22'h100000});
        run_op(16'h3E00, 16'h3E00, 0, 0);
        check("1p5_sq", dut_result(), {1'b0, 1'b0, 5'd15, 22'h240000});
        run_op(16'hC000, 16'h4200, 0, 0);
        check("neg_sign", dut_result(), {1'b1, 1'b0, 5'd17, 22'h180000});
        run_op(16'h0000, 16'h4500, 0, 0);
        check("zero_op", dut_result(), {1'b0, 1'b1, 5'd0, 22'd0});
        run_op(16'h0400, 16'h0400, 0, 0);
        check("underflow", dut_result(), {1'b0, 1'b1, 5'd0, 22'd0});
        run_op(16'h7800, 16'h7800, 0, 0);
        check("overflow", dut_result(), {1'b0, 1'b0, 5'd30, 22'h1FFFFF});
        run_op(16'hFBFF, 16'h3FFF, 5, 1);

        // Reset in the middle of an iteration
        a = 16'h7800; b = 16'hC200; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_outputs", dut_result(), 29'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h3C00, 16'h3C00, 0, 0);
        check("post_rst", dut_result(), {1'b0, 1'b0, 5'd15, 22'h100000});

        // Random operands; exponents biased around the zero/saturation boundaries
        for (int n = 0; n < 60; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra[14:10] = 5'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) rb[14:10] = 5'($urandom_range(14, 17));
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
